// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer.
// Entry layout (LSB first): data[31:0], addr[36:32], inst[68:37], pc[100:69],
// and with WB_TRACE_TIMESTAMP_EN defined, ts[132:101].
// Macro: WB_TRACE_TIMESTAMP_EN selects the 133-bit entry with a timestamp field.
package wb_trace_buffer_pkg;

`ifdef WB_TRACE_TIMESTAMP_EN
  localparam int TRACE_ENTRY_W = 133;
`else
  localparam int TRACE_ENTRY_W = 101;
`endif

  localparam int TRACE_DATA_LSB = 0;
  localparam int TRACE_ADDR_LSB = 32;
  localparam int TRACE_INST_LSB = 37;
  localparam int TRACE_PC_LSB   = 69;
  localparam int TRACE_TS_LSB   = 101;

  localparam logic [4:0] TRACE_REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_trace_buffer_fifo.sv
// Generic synchronous FIFO used by the trace buffer.
// Ports:
//   clk_i, rst_i       : rising-edge clock, synchronous active-high reset
//   push_i, wdata_i    : write request and data (accepted if not full, or full with pop)
//   pop_i              : read request (ignored when empty)
//   rdata_o            : head entry, combinational from the RAM read port
//   count_o            : occupancy, 0..DEPTH
//   full_o, empty_o    : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // When full, a simultaneous pop frees the head slot, which is exactly
  // where the write pointer sits; the new entry lands there as the tail.
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone says which slots are live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures every register-file write of the CPU
// into a FIFO and drains it through a valid/ready port.
// Ports:
//   clk_in, reset                 : CPU clock, synchronous active-high reset
//   trace_en                      : capture enable
//   pc, inst, rf_w, w_addr, w_data: per-cycle CPU debug outputs
//   out_valid/out_ready           : drain handshake
//   out_pc/inst/addr/data(/ts)    : head entry, zero when out_valid is low
//   count, almost_full            : occupancy and stall hint
//   overflow, drop_cnt, clr_ovf   : sticky drop flag, saturating drop counter, clear
// Macro: WB_TRACE_TIMESTAMP_EN adds a free-running cycle counter stored per
// entry and the out_ts output.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   trace_en,
  input  logic [31:0]            pc,
  input  logic [31:0]            inst,
  input  logic                   rf_w,
  input  logic [4:0]             w_addr,
  input  logic [31:0]            w_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [4:0]             out_addr,
  output logic [31:0]            out_data,
`ifdef WB_TRACE_TIMESTAMP_EN
  output logic [31:0]            out_ts,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  input  logic                   clr_ovf
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AF_LVL = (DEPTH > AF_MARGIN) ? (DEPTH - AF_MARGIN) : 0;
  localparam logic [CW-1:0] AF_LEVEL = CW'(AF_LVL);

  logic                     push, pop, drop;
  logic                     fifo_full, fifo_empty;
  logic [TRACE_ENTRY_W-1:0] wr_entry, head;
  logic                     overflow_q, overflow_d;
  logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;

  assign push = trace_en & rf_w & (w_addr != TRACE_REG_ZERO);
  assign pop  = out_valid & out_ready;
  // A pop on a full FIFO makes room, so only an unpaired push is lost.
  assign drop = push & fifo_full & ~pop;

`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk_in) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end

  assign wr_entry = {ts_q, pc, inst, w_addr, w_data};
`else
  assign wr_entry = {pc, inst, w_addr, w_data};
`endif

  trace_fifo #(
    .WIDTH (TRACE_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid   = ~fifo_empty;
  assign almost_full = (count >= AF_LEVEL);

  assign out_pc   = out_valid ? head[TRACE_PC_LSB   +: 32] : '0;
  assign out_inst = out_valid ? head[TRACE_INST_LSB +: 32] : '0;
  assign out_addr = out_valid ? head[TRACE_ADDR_LSB +: 5]  : '0;
  assign out_data = out_valid ? head[TRACE_DATA_LSB +: 32] : '0;
`ifdef WB_TRACE_TIMESTAMP_EN
  assign out_ts   = out_valid ? head[TRACE_TS_LSB   +: 32] : '0;
`endif

  // Clear takes priority over a drop in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int CNT_W     = 16;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              trace_en;
  logic [31:0]       pc, inst, w_data;
  logic              rf_w;
  logic [4:0]        w_addr;
  logic              out_valid, out_ready;
  logic [31:0]       out_pc, out_inst, out_data;
  logic [4:0]        out_addr;
`ifdef WB_TRACE_TIMESTAMP_EN
  logic [31:0]       out_ts;
`endif
  logic [$clog2(DEPTH):0] count;
  logic              almost_full, overflow, clr_ovf;
  logic [CNT_W-1:0]  drop_cnt;

  wb_trace_buffer #(
    .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .trace_en(trace_en),
    .pc(pc), .inst(inst), .rf_w(rf_w), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_addr(out_addr), .out_data(out_data),
`ifdef WB_TRACE_TIMESTAMP_EN
    .out_ts(out_ts),
`endif
    .count(count), .almost_full(almost_full), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] ts;
  } entry_t;

  entry_t      m_q[$];
  bit          m_ovf;
  int unsigned m_drop;
  int unsigned m_ts;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    entry_t h;
    bit     v;
    v = (m_q.size() != 0);
    h = v ? m_q[0] : '0;
    check_eq("out_valid", 64'(out_valid), 64'(v));
    check_eq("count", 64'(count), 64'(m_q.size()));
    check_eq("almost_full", 64'(almost_full), 64'((DEPTH - m_q.size()) <= AF_MARGIN));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check_eq("out_pc", 64'(out_pc), 64'(h.pc));
    check_eq("out_inst", 64'(out_inst), 64'(h.inst));
    check_eq("out_addr", 64'(out_addr), 64'(h.addr));
    check_eq("out_data", 64'(out_data), 64'(h.data));
`ifdef WB_TRACE_TIMESTAMP_EN
    check_eq("out_ts", 64'(out_ts), 64'(h.ts));
`endif
  endtask

  // Check outputs, then advance one clock while updating the model from the
  // inputs that were applied during that cycle.
  task automatic tick();
    bit     push, pop;
    entry_t e;
    check_outputs();
    push = trace_en && rf_w && (w_addr != 5'd0);
    pop  = (m_q.size() != 0) && out_ready;
    e.pc = pc; e.inst = inst; e.addr = w_addr; e.data = w_data; e.ts = m_ts;
    @(posedge clk_in);
    if (reset) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_ts   = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else if (!clr_ovf) begin
          m_ovf = 1'b1;
          if (m_drop < (2**CNT_W - 1)) m_drop++;
        end
      end
      if (clr_ovf) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
      m_ts++;
    end
    #1;
  endtask

  task automatic drive(input bit en, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic [31:0] i, input bit rdy, input bit clr);
    trace_en = en; rf_w = w; w_addr = a; w_data = d; pc = p; inst = i;
    out_ready = rdy; clr_ovf = clr;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle(1'b0);
    m_ovf = 1'b0; m_drop = 0; m_ts = 0;
    @(negedge clk_in);
    tick(); tick();
    reset = 1'b0;

    // Reset then idle
    tick();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);

    // Three captures held back, then drained in order
    drive(1, 1, 5'd1, 32'h0040_0000, 32'h0040_0000, 32'h3C01_0040, 0, 0); tick();
    drive(1, 1, 5'd2, 32'h0000_0005, 32'h0040_0004, 32'h2402_0005, 0, 0); tick();
    drive(1, 1, 5'd3, 32'h0000_0007, 32'h0040_0008, 32'h2403_0007, 0, 0); tick();
    idle(1'b0); tick();
    check_eq("three_count", 64'(count), 64'd3);
    check_eq("three_head_pc", 64'(out_pc), 64'h0040_0000);
    check_eq("three_head_inst", 64'(out_inst), 64'h3C01_0040);
    idle(1'b1);
    check_eq("drain0_pc", 64'(out_pc), 64'h0040_0000); tick();
    check_eq("drain1_pc", 64'(out_pc), 64'h0040_0004); tick();
    check_eq("drain2_pc", 64'(out_pc), 64'h0040_0008); tick();
    check_eq("drained_valid", 64'(out_valid), 64'd0);

    // Writes to $0 are never captured
    drive(1, 1, 5'd0, 32'hDEAD_BEEF, 32'h0040_000C, 32'h2400_0001, 0, 0); tick();
    idle(1'b0); tick();
    check_eq("r0_count", 64'(count), 64'd0);

    // 18 pushes into a 16-deep FIFO
    for (int k = 0; k < 18; k++) begin
      drive(1, 1, 5'(1 + (k % 31)), 32'h1000 + 32'(k), 32'h0050_0000 + 32'(4*k), 32'h2000_0000 + 32'(k), 0, 0);
      tick();
      if (k == 12) check_eq("af_at_13", 64'(almost_full), 64'd0);
      if (k == 13) check_eq("af_at_14", 64'(almost_full), 64'd1);
    end
    idle(1'b0); tick();
    check_eq("full_count", 64'(count), 64'd16);
    check_eq("full_ovf", 64'(overflow), 64'd1);
    check_eq("full_drop", 64'(drop_cnt), 64'd2);
    drive(1, 0, 5'd0, 0, 0, 0, 0, 1); tick();
    idle(1'b0); tick();
    check_eq("clr_ovf", 64'(overflow), 64'd0);
    check_eq("clr_drop", 64'(drop_cnt), 64'd0);
    check_eq("clr_count", 64'(count), 64'd16);

    // Clear wins over a simultaneous drop
    drive(1, 1, 5'd9, 32'h99, 32'h0077_0000, 32'h1, 0, 1); tick();
    idle(1'b0); tick();
    check_eq("clr_vs_drop_ovf", 64'(overflow), 64'd0);
    check_eq("clr_vs_drop_cnt", 64'(drop_cnt), 64'd0);

    // Full with push and pop together
    drive(1, 1, 5'd7, 32'h1234_5678, 32'hABCD_0000, 32'h2407_0001, 1, 0); tick();
    idle(1'b0); tick();
    check_eq("fpp_count", 64'(count), 64'd16);
    check_eq("fpp_drop", 64'(drop_cnt), 64'd0);
    idle(1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check_eq("fpp_16th_pc", 64'(out_pc), 64'hABCD_0000);
      tick();
    end
    check_eq("fpp_empty", 64'(out_valid), 64'd0);

    // Reset with five entries queued
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 5'd4, 32'(k), 32'h0060_0000 + 32'(4*k), 32'h3, 0, 0);
      tick();
    end
    idle(1'b0);
    check_eq("pre_rst_count", 64'(count), 64'd5);
    reset = 1'b1; tick();
    reset = 1'b0;
    check_eq("mid_rst_count", 64'(count), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    tick(); tick(); tick();
    drive(1, 1, 5'd5, 32'h55, 32'h0070_0000, 32'h4, 0, 0); tick();
    idle(1'b0);
`ifdef WB_TRACE_TIMESTAMP_EN
    check_eq("ts_after_rst", 64'(out_ts), 64'd3);
`endif
    check_eq("post_rst_pc", 64'(out_pc), 64'h0070_0000);

    // Randomized traffic with phases biased toward filling or draining
    for (int k = 0; k < 3000; k++) begin
      int unsigned rdy_pct;
      rdy_pct = ((k / 200) % 3 == 0) ? 20 : (((k / 200) % 3 == 1) ? 50 : 85);
      trace_en  = ($urandom_range(0, 7) != 0);
      rf_w      = ($urandom_range(0, 3) != 0);
      w_addr    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w_data    = $urandom;
      pc        = $urandom;
      inst      = $urandom;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      clr_ovf   = ($urandom_range(0, 40) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    idle(1'b0);
    tick();
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream observer of the single-cycle CPU top. Consumes its per-cycle debug outputs (pc, inst, register-file write strobe, write address, write data).
- Captures every register write-back event into an on-chip FIFO.
- The FIFO drains through a valid/ready port to a debug consumer (UART bridge or bench scoreboard).
- Provides an almost-full stall hint that the top can use to gate its clock.

Parameters:
- DEPTH, 16: FIFO entries; power of two, minimum 4.
- AF_MARGIN, 2: almost_full asserts when free slots <= AF_MARGIN.
- CNT_W, 16: width of the dropped-event counter.

Ports:
- clk_in, input, 1: CPU clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high.
- trace_en, input, 1: capture enable.
- pc, input, 32: PC of the current instruction.
- inst, input, 32: current instruction word.
- rf_w, input, 1: register-file write strobe for this cycle.
- w_addr, input, 5: write-back register number.
- w_data, input, 32: write-back data.
- out_valid, output, 1: head entry available.
- out_ready, input, 1: consumer accepts the head entry.
- out_pc, output, 32: head entry PC.
- out_inst, output, 32: head entry instruction.
- out_addr, output, 5: head entry register number.
- out_data, output, 32: head entry write data.
- count, output, clog2(DEPTH)+1: current occupancy.
- almost_full, output, 1: free slots <= AF_MARGIN.
- overflow, output, 1: sticky; set on any dropped event.
- drop_cnt, output, CNT_W: number of dropped events, saturating.
- clr_ovf, input, 1: clears overflow and drop_cnt.

Behaviour:
- Clock and reset: one clock (clk_in). Reset is synchronous and active-high.
- Reset values: all outputs 0. Pointers, count, overflow and drop_cnt are 0. RAM contents are not reset.
- Reset mid-operation: all entries are discarded on the next edge. Capture and pop are suppressed in the reset cycle.
- push = trace_en & rf_w & (w_addr != 0). Writes to $0 are never captured.
- pop = out_valid & out_ready.
- out_valid = (count != 0).
- out_* show the head entry combinationally from the RAM read port. When out_valid = 0, out_* are forced to 0.
- Latency: an entry pushed on edge N is visible on out_* after edge N. There is no same-cycle fall-through.
- Push and pop in the same cycle when not full and not empty: count is unchanged and both pointers advance.
- Push and pop in the same cycle when full: the push is accepted, count stays DEPTH, and no drop occurs.
- Push and pop in the same cycle when empty: out_valid is 0, so pop is impossible; the push is accepted.
- Push when full without pop: the event is dropped. overflow is set to 1 and drop_cnt increments, saturating at all-ones.
- Pop when empty: ignored.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count carries the full/empty distinction.
- clr_ovf: overflow and drop_cnt are cleared on the next edge. If a drop happens in the same cycle, clear wins and the drop is not counted. Entries are unaffected.
- almost_full = (DEPTH - count) <= AF_MARGIN, computed from the registered count.
- trace_en deasserted: no capture. Draining continues.

Optional Feature:
- Macro: WB_TRACE_TIMESTAMP_EN.
- With the macro defined:
  - A 32-bit free-running cycle counter is present. It is 0 at reset and increments every cycle, wrapping.
  - Each entry also stores the counter value at capture time.
  - An extra output, out_ts (32 bits), is driven like the other out_* fields.
- Without the macro: no counter, no out_ts port, and the entry width is 101 bits.

Decomposition:
- Shared package/header holds:
  - TRACE_ENTRY_W: 101, or 133 with the timestamp.
  - Field offset constants for PC, INST, ADDR, DATA and TS within the entry.
  - TRACE_REG_ZERO (5'd0).
- One sub-module: trace_fifo.
  - Generic synchronous FIFO parameterised by width and depth.
  - Provides push, pop, head data, count and full/empty.
- The top-level holds:
  - push qualification;
  - overflow and drop counter;
  - almost_full;
  - timestamp;
  - entry packing/unpacking.

Test Plan:
- Reset then idle: out_valid = 0, count = 0, out_pc = 0, overflow = 0.
- Three writes with out_ready = 0:
  - Writes are (pc 0x00400000, inst 0x3C010040, w_addr 1, w_data 0x00400000), then pc 0x00400004 with w_addr 2, then pc 0x00400008 with w_addr 3.
  - Expect count = 3 and the head is the 0x00400000 entry.
  - Then set out_ready = 1: the three entries emerge in order over three cycles, then out_valid = 0.
- rf_w = 1 with w_addr = 0 and w_data = 0xDEADBEEF: no capture, count stays 0.
- DEPTH = 16, out_ready = 0:
  - 18 pushes: count = 16, almost_full asserted from count = 14, overflow = 1, drop_cnt = 2.
  - Then pulse clr_ovf: overflow = 0 and drop_cnt = 0, with count still 16.
- Full FIFO with push and pop in the same cycle: count stays 16, drop_cnt is unchanged, and the new entry appears as the 16th pop.
- Assert reset with 5 entries queued: on the next edge count = 0 and out_valid = 0. With WB_TRACE_TIMESTAMP_EN, the next capture's out_ts equals the number of cycles since reset deassertion.
